// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_t       : controller state encoding (IDLE, CONV, DONE)
//   BCD_MAX_DIGIT : largest legal BCD digit value
//   ADJ           : correction subtracted from a digit during reverse double-dabble
//   ADJ_THRESH    : digit value at or above which the correction applies
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] ADJ           = 4'd3;
    localparam logic [3:0] ADJ_THRESH    = 4'd8;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step for the reverse double-dabble algorithm.
//   digit_in  : 4-bit BCD digit after the right shift
//   digit_out : digit_in - 3 when digit_in >= 8, otherwise digit_in
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in - ADJ;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, sampled only in IDLE
//   bcd_in  : NDIG packed BCD digits, digit 0 in bits [3:0]
//   bin_out : binary result, held from done until the next accepted start
//   busy    : high while shifting (CONV)
//   done    : one-cycle pulse, bin_out/err valid
//   err     : sampled input contained a digit greater than 9
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 3,
    parameter int unsigned BW   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic [BW-1:0]       bin_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned SW = 4*NDIG + BW;
    localparam int unsigned CW = $clog2(BW + 1);

    state_t          state_q,   state_d;
    logic [SW-1:0]   sreg_q,    sreg_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [BW-1:0]   bin_out_q, bin_out_d;
    logic            err_q,     err_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic            hold_q,    hold_d;

    logic [SW-1:0]     shifted;
    logic [SW-1:0]     adjusted;
    logic [4*NDIG-1:0] adj_bcd;
    logic              bad_digit;

    assign shifted = sreg_q >> 1;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (shifted[BW + 4*g +: 4]),
            .digit_out (adj_bcd[4*g +: 4])
        );
    end

    assign adjusted = {adj_bcd, shifted[BW-1:0]};

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX_DIGIT) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        hold_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        // Invalid input skips CONV; DONE is entered with done
                        // held back one cycle (hold) so done lands two edges
                        // after the start edge.
                        err_d     = 1'b1;
                        bin_out_d = '0;
                        hold_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        sreg_d  = {bcd_in, {BW{1'b0}}};
                        cnt_d   = CW'(BW);
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sreg_d = adjusted;
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
                if (cnt_d == '0) begin
                    bin_out_d = adjusted[BW-1:0];
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (hold_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hold_q    <= hold_d;
        end
    end

    assign bin_out = bin_out_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
